// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: owns the cipher state, fetches one round key per
// handshake, XORs it onto the external round datapath result and hands back the ciphertext.
module aes_round_sequencer #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [127:0]  block_in,
    output logic          key_req,
    input  logic          key_valid,
    input  logic [127:0]  round_key,
    output logic [RW-1:0] round_idx,
    output logic [127:0]  dp_state,
    output logic          dp_last,
    input  logic [127:0]  dp_result,
    output logic          done_valid,
    input  logic          done_ready,
    output logic [127:0]  block_out,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, KEY0, ROUND, DONE} fsm_e;

    localparam logic [RW-1:0] LAST_IDX = RW'(NR);

    fsm_e          fsm_q, fsm_d;
    logic [127:0]  state_q, state_d;
    logic [RW-1:0] idx_q, idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        idx_d       = idx_q;
        start_ready = 1'b0;
        key_req     = 1'b0;
        done_valid  = 1'b0;
        case (fsm_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    state_d = block_in;
                    idx_d   = '0;
                    fsm_d   = KEY0;
                end
            end
            KEY0: begin
                // Initial AddRoundKey: the datapath is not involved
                key_req = 1'b1;
                if (key_valid) begin
                    state_d = state_q ^ round_key;
                    idx_d   = RW'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                key_req = 1'b1;
                if (key_valid) begin
                    state_d = dp_result ^ round_key;
                    if (idx_q == LAST_IDX) fsm_d = DONE;
                    else                   idx_d = idx_q + RW'(1);
                end
            end
            DONE: begin
                done_valid = 1'b1;
                // Clear on drain so no ciphertext lingers on dp_state/block_out
                if (done_ready) begin
                    fsm_d   = IDLE;
                    idx_d   = '0;
                    state_d = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign round_idx = idx_q;
    assign dp_state  = state_q;
    assign dp_last   = (fsm_q == ROUND) && (idx_q == LAST_IDX);
    assign block_out = state_q;
    assign busy      = (fsm_q != IDLE);

endmodule
